input_fetch_loader: RTL and testbench
=====================================

// Module: input_fetch_loader
// PURPOSE
//  Upstream feeder for the conv controller's GETTING_INPUT phase.
//  - Issues INPUT_DEPTH in-order word reads from external memory, starting at BASE_ADDR.
//  - Writes each returned 16-bit word into the input buffer at consecutive indices 0..INPUT_DEPTH-1.
//  - Word = two packed 8-bit activations (22x22x64 = 30976 -> 15488 words).
//  - Pulses done so the controller can advance to GETTING_WEIGHT.
// PARAMETERS
//  INPUT_DEPTH     15488  words to load per start
//  BUS_BW          16     memory data / buffer word width
//  ADDR_BW         16     memory address width
//  BUF_AW          14     buffer index width (2**BUF_AW >= INPUT_DEPTH)
//  BASE_ADDR       0      first memory word address
//  MAX_OUTSTANDING 4      max accepted-but-unanswered reads (>=1)
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-high reset
//  start      in   1        begin a load; sampled only in IDLE
//  busy       out  1        high in FETCH or DRAIN
//  done       out  1        1-cycle pulse, same cycle as final buf_we
//  err        out  1        sticky protocol error; cleared by accepted start
//  mem_req    out  1        read request valid
//  mem_gnt    in   1        request accepted when mem_req&&mem_gnt
//  mem_addr   out  ADDR_BW  read address, stable while mem_req&&!mem_gnt
//  mem_rvalid in   1        read data valid; responses return in request order
//  mem_rdata  in   BUS_BW   read data
//  buf_we     out  1        buffer write strobe
//  buf_waddr  out  BUF_AW   buffer write index
//  buf_wdata  out  BUS_BW   buffer write data
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE; all counters 0.
//  - Outputs 0: busy, done, err, mem_req, mem_addr, buf_we, buf_waddr, buf_wdata.
//  FSM: IDLE -> FETCH -> DRAIN -> IDLE.
//  - IDLE: start=1 clears counters and err, goes to FETCH. mem_req first high the next cycle.
//  - FETCH: mem_req = (issued<INPUT_DEPTH) && (outstanding<MAX_OUTSTANDING).
//    - On accept: mem_addr increments, issued++.
//    - Go to DRAIN the cycle after the accept that makes issued==INPUT_DEPTH.
//  - DRAIN: mem_req=0. Return to IDLE in the cycle done pulses.
//  outstanding: +1 on accept, -1 on mem_rvalid; both in the same cycle -> unchanged.
//  - Never exceeds MAX_OUTSTANDING.
//  Response path, registered, latency 1:
//  - mem_rvalid at cycle t -> buf_we=1 at t+1 with buf_wdata=mem_rdata(t), buf_waddr=received count.
//  - received++ at t+1; buf_waddr wraps to 0 after INPUT_DEPTH-1 (next load).
//  - buf_we is 1 only in cycles following a valid response; no bubbles inserted.
//  done: high exactly in the cycle of the write with buf_waddr==INPUT_DEPTH-1.
//  - FSM is IDLE the next cycle; start may be accepted that next cycle.
//  start while busy: ignored; no effect on counters or outputs.
//  Protocol errors:
//  - mem_rvalid with outstanding==0 (counting same-cycle accept) -> err=1.
//  - The response is discarded; no buf_we.
//  - err holds until the next accepted start or reset.
//  mem_gnt while mem_req=0: ignored.
//  Reset mid-load: load abandoned, no done. Late mem_rvalid after reset sets err (outstanding=0).
//  Counters sized to hold INPUT_DEPTH without overflow.
// TESTING
//  1 Ideal memory (gnt=1, rvalid 1 cycle after accept), INPUT_DEPTH=8, data=addr^16'hA5A5.
//    -> 8 writes idx 0..7 with matching data; done with idx 7; busy low next cycle.
//  2 Stalled gnt (accept every 3rd cycle) plus rvalid latency 5, MAX_OUTSTANDING=4.
//    -> outstanding never >4; mem_addr stable under stall; all 8 words in order.
//  3 Memory holds 10 responses.
//    -> mem_req drops after 4 accepts; resumes one cycle after the first rvalid.
//  4 start pulses during FETCH and in the done cycle.
//    -> first ignored; a start the cycle after done launches a clean second load from idx 0.
//  5 Async reset asserted after 3 writes, then a stray rvalid.
//    -> all outputs 0 immediately; stray rvalid sets err, no buf_we; next start clears err.
//  6 Full default INPUT_DEPTH=15488, random gnt/latency.
//    -> exactly 15488 writes, last idx 15487, one done pulse, err=0.

Source files
------------

// File: rtl/input_fetch_loader.sv
// Streams INPUT_DEPTH words from external memory into the input buffer for the conv controller.
// Reads are issued in order with a bounded number in flight; responses are written one cycle later.
module input_fetch_loader #(
    parameter int INPUT_DEPTH     = 15488,
    parameter int BUS_BW          = 16,
    parameter int ADDR_BW         = 16,
    parameter int BUF_AW          = 14,
    parameter int BASE_ADDR       = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               mem_req,
    input  logic               mem_gnt,
    output logic [ADDR_BW-1:0] mem_addr,
    input  logic               mem_rvalid,
    input  logic [BUS_BW-1:0]  mem_rdata,
    output logic               buf_we,
    output logic [BUF_AW-1:0]  buf_waddr,
    output logic [BUS_BW-1:0]  buf_wdata
);

    localparam int ISS_W = $clog2(INPUT_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ISS_W-1:0]  DEPTH_C    = ISS_W'(INPUT_DEPTH);
    localparam logic [ISS_W-1:0]  LAST_ISSUE = ISS_W'(INPUT_DEPTH - 1);
    localparam logic [OUT_W-1:0]  MAX_OUT_C  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [BUF_AW-1:0] LAST_IDX   = BUF_AW'(INPUT_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state;
    state_t            next_state;
    logic [ISS_W-1:0]  issued;
    logic [OUT_W-1:0]  outstanding;
    logic [BUF_AW-1:0] received;
    logic              accept;
    logic              resp_ok;
    logic              start_ok;

    // A response is legal if something is in flight, including a read accepted this same cycle.
    assign accept   = mem_req && mem_gnt;
    assign resp_ok  = mem_rvalid && ((outstanding != '0) || accept);
    assign start_ok = (state == IDLE) && start;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                mem_req = (issued < DEPTH_C) && (outstanding < MAX_OUT_C);
                if (mem_req && mem_gnt && (issued == LAST_ISSUE)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request-side bookkeeping; a stray response sets err after any start clear so it is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued      <= '0;
            outstanding <= '0;
            received    <= '0;
            mem_addr    <= '0;
            err         <= 1'b0;
        end else begin
            if (start_ok) begin
                issued   <= '0;
                received <= '0;
                mem_addr <= ADDR_BW'(BASE_ADDR);
                err      <= 1'b0;
            end
            if (accept) begin
                issued   <= issued + 1'b1;
                mem_addr <= mem_addr + 1'b1;
            end
            case ({accept, resp_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (resp_ok) begin
                received <= (received == LAST_IDX) ? '0 : received + 1'b1;
            end
            if (mem_rvalid && !resp_ok) begin
                err <= 1'b1;
            end
        end
    end

    // Registered write port; done rides along with the write of the final index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_we    <= 1'b0;
            buf_waddr <= '0;
            buf_wdata <= '0;
            done      <= 1'b0;
        end else begin
            buf_we <= resp_ok;
            done   <= resp_ok && (received == LAST_IDX);
            if (resp_ok) begin
                buf_waddr <= received;
                buf_wdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_input_fetch_loader.sv
// Bench for input_fetch_loader: a small-depth and a full-depth instance share one memory model,
// with a transaction-level reference tracking requests, responses and buffer writes.
module tb_input_fetch_loader;

    localparam int SMALL_N = 8;
    localparam int BIG_N   = 15488;
    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    int          sel;

    logic        s_busy, s_done, s_err, s_req, s_we;
    logic [15:0] s_addr, s_wdata;
    logic [13:0] s_waddr;
    logic        b_busy, b_done, b_err, b_req, b_we;
    logic [15:0] b_addr, b_wdata;
    logic [13:0] b_waddr;

    logic        o_busy, o_done, o_err, o_req, o_we;
    logic [15:0] o_addr, o_wdata;
    logic [13:0] o_waddr;

    always #5 clk = ~clk;

    input_fetch_loader #(.INPUT_DEPTH(SMALL_N)) dut_small (
        .clk(clk), .reset(reset), .start(start && (sel == 0)),
        .busy(s_busy), .done(s_done), .err(s_err),
        .mem_req(s_req), .mem_gnt(mem_gnt && (sel == 0)), .mem_addr(s_addr),
        .mem_rvalid(mem_rvalid && (sel == 0)), .mem_rdata(mem_rdata),
        .buf_we(s_we), .buf_waddr(s_waddr), .buf_wdata(s_wdata)
    );

    input_fetch_loader dut_big (
        .clk(clk), .reset(reset), .start(start && (sel == 1)),
        .busy(b_busy), .done(b_done), .err(b_err),
        .mem_req(b_req), .mem_gnt(mem_gnt && (sel == 1)), .mem_addr(b_addr),
        .mem_rvalid(mem_rvalid && (sel == 1)), .mem_rdata(mem_rdata),
        .buf_we(b_we), .buf_waddr(b_waddr), .buf_wdata(b_wdata)
    );

    assign o_busy  = (sel == 1) ? b_busy  : s_busy;
    assign o_done  = (sel == 1) ? b_done  : s_done;
    assign o_err   = (sel == 1) ? b_err   : s_err;
    assign o_req   = (sel == 1) ? b_req   : s_req;
    assign o_addr  = (sel == 1) ? b_addr  : s_addr;
    assign o_we    = (sel == 1) ? b_we    : s_we;
    assign o_waddr = (sel == 1) ? b_waddr : s_waddr;
    assign o_wdata = (sel == 1) ? b_wdata : s_wdata;

    typedef struct {
        int due;
        logic [15:0] data;
    } resp_t;

    typedef struct {
        int sel;
        int gnt_period;
        int lat_min;
        int lat_max;
        int exp_writes;
        int exp_peak;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;

    int          cyc = 0;
    bit          active = 0;
    int          issued = 0;
    int          outs = 0;
    int          peak = 0;
    int          widx = 0;
    int          writes = 0;
    int          dones = 0;
    int          loads_done = 0;
    int          last_due = 0;
    bit          pend_we = 0;
    logic [15:0] pend_data = '0;
    bit          exp_err = 0;
    bit          stray = 0;
    int          gnt_period = 1;
    int          lat_min = 1;
    int          lat_max = 1;
    resp_t       rq[$];

    function automatic int cur_n();
        return (sel == 1) ? BIG_N : SMALL_N;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        check_output("rst_busy", o_busy, 0);
        check_output("rst_done", o_done, 0);
        check_output("rst_err", o_err, 0);
        check_output("rst_mem_req", o_req, 0);
        check_output("rst_mem_addr", o_addr, 0);
        check_output("rst_buf_we", o_we, 0);
        check_output("rst_buf_waddr", o_waddr, 0);
        check_output("rst_buf_wdata", o_wdata, 0);
    endtask

    // One clock cycle: check outputs against the model, then let the memory react and drive inputs.
    task automatic apply_stimulus(input bit st, input bit st_on_done);
        int          n;
        int          due;
        bit          exp_req, last_write, was_active, gnt, acc, rv, from_q, st_eff;
        logic [15:0] data;
        resp_t       r;
        n = cur_n();
        exp_req = active && (issued < n) && (outs < MAX_OUT);
        check_output("busy", o_busy, active);
        check_output("mem_req", o_req, exp_req);
        if (o_req && exp_req) check_output("mem_addr", o_addr, issued);
        check_output("buf_we", o_we, pend_we);
        if (o_we && pend_we) begin
            check_output("buf_waddr", o_waddr, widx);
            check_output("buf_wdata", o_wdata, pend_data);
        end
        last_write = pend_we && (widx == n - 1);
        check_output("done", o_done, last_write);
        check_output("err", o_err, exp_err);
        if (o_we) writes++;
        if (o_done) dones++;
        if (pend_we) widx = (widx + 1) % n;
        if (last_write) loads_done++;
        was_active = active;
        if (last_write) active = 0;

        gnt = (gnt_period == 0) ? 1'($urandom_range(0, 1)) : ((cyc % gnt_period) == 0);
        acc = o_req && gnt;
        rv = 0;
        from_q = 0;
        data = 16'($urandom);
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            rv = 1;
            from_q = 1;
            data = r.data;
            outs--;
        end else if (stray) begin
            // Only injected while nothing is in flight, so it must be flagged.
            rv = 1;
            stray = 0;
            exp_err = 1;
        end
        if (acc) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.due = due;
            r.data = 16'(issued) ^ 16'hA5A5;
            rq.push_back(r);
            issued++;
            outs++;
            if (outs > peak) peak = outs;
        end
        pend_we = from_q;
        pend_data = data;

        st_eff = st || (st_on_done && last_write);
        if (st_eff && !was_active) begin
            active = 1;
            issued = 0;
            widx = 0;
            exp_err = 0;
            last_due = cyc;
        end
        start = st_eff;
        mem_gnt = gnt;
        mem_rvalid = rv;
        mem_rdata = data;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_done(input int budget, input bit st_on_done);
        int target;
        int k;
        target = loads_done + 1;
        k = 0;
        while (loads_done < target && k < budget) begin
            apply_stimulus(0, st_on_done);
            k++;
        end
        if (loads_done < target) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL load_timeout: got %0d writes after %0d cycles", writes, budget);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   k;
        vecs[0] = '{sel: 0, gnt_period: 1, lat_min: 1,  lat_max: 1,  exp_writes: SMALL_N, exp_peak: 1};
        vecs[1] = '{sel: 0, gnt_period: 3, lat_min: 5,  lat_max: 5,  exp_writes: SMALL_N, exp_peak: 2};
        vecs[2] = '{sel: 0, gnt_period: 1, lat_min: 10, lat_max: 10, exp_writes: SMALL_N, exp_peak: 4};
        vecs[3] = '{sel: 0, gnt_period: 0, lat_min: 1,  lat_max: 6,  exp_writes: SMALL_N, exp_peak: -1};
        vecs[4] = '{sel: 0, gnt_period: 0, lat_min: 1,  lat_max: 3,  exp_writes: SMALL_N, exp_peak: -1};
        vecs[5] = '{sel: 1, gnt_period: 0, lat_min: 1,  lat_max: 6,  exp_writes: BIG_N,   exp_peak: -1};

        reset = 1'b1;
        start = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        sel = 0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(0, 0);

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            gnt_period = vecs[i].gnt_period;
            lat_min = vecs[i].lat_min;
            lat_max = vecs[i].lat_max;
            writes = 0;
            dones = 0;
            peak = 0;
            apply_stimulus(1, 0);
            run_until_done((sel == 1) ? 80000 : 500, 0);
            apply_stimulus(0, 0);
            check_output("write_count", writes, vecs[i].exp_writes);
            check_output("done_count", dones, 1);
            if (vecs[i].exp_peak >= 0) check_output("peak_outstanding", peak, vecs[i].exp_peak);
            else check_output("peak_within_limit", peak <= MAX_OUT, 1);
        end

        // Starts during FETCH and in the done cycle are ignored; one right after done reloads.
        sel = 0;
        gnt_period = 1;
        lat_min = 2;
        lat_max = 2;
        writes = 0;
        dones = 0;
        apply_stimulus(1, 0);
        apply_stimulus(0, 0);
        apply_stimulus(1, 0);
        run_until_done(500, 1);
        apply_stimulus(1, 0);
        run_until_done(500, 0);
        apply_stimulus(0, 0);
        check_output("restart_writes", writes, 2 * SMALL_N);
        check_output("restart_dones", dones, 2);

        // Abandon a load with async reset, then a stray response must raise err until next start.
        lat_min = 3;
        lat_max = 3;
        writes = 0;
        dones = 0;
        apply_stimulus(1, 0);
        k = 0;
        while (writes < 3 && k < 200) begin
            apply_stimulus(0, 0);
            k++;
        end
        check_output("writes_before_reset", writes, 3);
        reset = 1'b1;
        start = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        check_reset_outputs();
        active = 0;
        issued = 0;
        outs = 0;
        widx = 0;
        pend_we = 0;
        exp_err = 0;
        rq.delete();
        @(negedge clk);
        reset = 1'b0;
        cyc++;
        apply_stimulus(0, 0);
        stray = 1;
        apply_stimulus(0, 0);
        apply_stimulus(0, 0);
        apply_stimulus(0, 0);
        dones = 0;
        apply_stimulus(1, 0);
        run_until_done(500, 0);
        apply_stimulus(0, 0);
        check_output("post_reset_dones", dones, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
